// File: rtl/basket_controller.sv
// basket_controller: ordered (ProductID, quantity) basket with merge-on-add, shifting remove and clear.
module basket_controller #(
  parameter int MAX_ITEMS = 8,
  parameter int NUM_PRODUCTS = 12
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       Add_En,
  input  logic [3:0] ProductID_in,
  input  logic [3:0] ProductQuantity_in,
  input  logic       Remove_En,
  input  logic [3:0] RemoveIndex_in,
  input  logic       Clear_En,
  input  logic [3:0] Read_Index,
  output logic [3:0] Read_ProductID,
  output logic [3:0] Read_Quantity,
  output logic [3:0] BasketProductNum,
  output logic       Full,
  output logic       Busy,
  output logic       Done,
  output logic       Rejected,
  output logic       Saturated
);
  localparam int IW = $clog2(MAX_ITEMS);
  localparam logic [3:0] MAX = 4'(MAX_ITEMS);
  localparam logic [4:0] NP = 5'(NUM_PRODUCTS);
  typedef enum logic [1:0] {IDLE, SEARCH, SHIFT} state_t;
  state_t state, state_n;
  logic [7:0] slot [MAX_ITEMS];
  logic [3:0] count, idx, add_id, add_qty;
  logic [IW-1:0] ix, nx;
  logic [7:0] cur;
  logic [4:0] sum;
  logic rej_q, rej_imm, rej, done, sat, merge, append, start_add, start_rem, shift_last, abort;
  assign ix = idx[IW-1:0];
  assign nx = ix + 1'b1;
  assign cur = slot[ix];
  assign sum = {1'b0, cur[3:0]} + {1'b0, add_qty};
  assign abort = RESET | Clear_En;
  always_comb begin
    state_n = state;
    rej_imm = 1'b0;
    rej = 1'b0;
    done = 1'b0;
    sat = 1'b0;
    merge = 1'b0;
    append = 1'b0;
    start_add = 1'b0;
    start_rem = 1'b0;
    shift_last = 1'b0;
    if (state == IDLE) begin
      if (Remove_En) begin
        start_rem = RemoveIndex_in < count;
        rej_imm = !start_rem;
        state_n = start_rem ? SHIFT : IDLE;
      end else if (Add_En) begin
        start_add = ({1'b0, ProductID_in} < NP) && (ProductQuantity_in != 4'd0);
        rej_imm = !start_add;
        state_n = start_add ? SEARCH : IDLE;
      end
    end else begin
      rej_imm = Add_En | Remove_En;
      if (state == SEARCH) begin
        if (idx < count && cur[7:4] == add_id) begin
          merge = 1'b1;
          done = 1'b1;
          sat = sum[4];
          state_n = IDLE;
        end else if (idx == count) begin
          append = count < MAX;
          done = append;
          rej = !append;
          state_n = IDLE;
        end
      end else if (idx == count - 4'd1) begin
        shift_last = 1'b1;
        done = 1'b1;
        state_n = IDLE;
      end
    end
    if (Clear_En) state_n = IDLE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (abort) begin
      state <= IDLE;
      count <= '0;
      idx <= '0;
      rej_q <= 1'b0;
      for (int i = 0; i < MAX_ITEMS; i++) slot[i] <= '0;
    end else begin
      state <= state_n;
      rej_q <= rej_imm;
      if (start_add) begin
        add_id <= ProductID_in;
        add_qty <= ProductQuantity_in;
        idx <= '0;
      end
      if (start_rem) idx <= RemoveIndex_in;
      if (state == SEARCH && state_n == SEARCH) idx <= idx + 4'd1;
      if (merge) slot[ix] <= {add_id, sum[4] ? 4'hf : sum[3:0]};
      if (append) begin
        slot[count[IW-1:0]] <= {add_id, add_qty};
        count <= count + 4'd1;
      end
      if (state == SHIFT && state_n == SHIFT) begin
        slot[ix] <= slot[nx];
        idx <= idx + 4'd1;
      end
      if (shift_last) begin
        slot[ix] <= '0;
        count <= count - 4'd1;
      end
    end
  end
  // Out-of-range reads return an empty slot for the display.
  assign {Read_ProductID, Read_Quantity} = (Read_Index < MAX) ? slot[Read_Index[IW-1:0]] : 8'd0;
  assign BasketProductNum = count;
  assign Full = count == MAX;
  assign Busy = state != IDLE;
  assign Done = done & !abort;
  assign Saturated = sat & !abort;
  assign Rejected = rej_q | (rej & !abort);
endmodule
